iter_result_collector: RTL and testbench

ITER_RESULT_COLLECTOR -- requirements
Module: iter_result_collector

---
 rtl/iter_result_collector.sv | 175 +++++++++++++++++
 tb/tb_iter_result_collector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iter_result_collector.sv
// Collects Mandelbrot iterator results round-robin, colours them and writes them to a framebuffer.
// Optional ITER_COLOR_MAP_EN selects the thresholded palette instead of a clamped grey ramp.
module iter_result_collector #(
    parameter int NUM_ITER = 2,
    parameter int MAX_ITER = 100,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_ITER-1:0]      res_valid,
    output logic [NUM_ITER-1:0]      res_ready,
    input  logic [10*NUM_ITER-1:0]   res_x,
    input  logic [9*NUM_ITER-1:0]    res_y,
    input  logic [11*NUM_ITER-1:0]   res_count,
    input  logic [18:0]              total_pixels,
    output logic [18:0]              mem_addr,
    output logic [7:0]               mem_data,
    output logic                     mem_we,
    input  logic                     mem_ack,
    output logic                     frame_done,
    output logic [15:0]              drop_count
);

    localparam int          PW    = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [9:0]  V_LIM = 10'(V_RES);
    localparam logic [10:0] MAX_C = 11'(MAX_ITER);

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  rrPtr_q, rrPtr_d;
    logic [9:0]     x_q, x_d;
    logic [8:0]     y_q, y_d;
    logic [10:0]    count_q, count_d;
    logic [18:0]    memAddr_q, memAddr_d;
    logic [7:0]     memData_q, memData_d;
    logic [15:0]    dropCount_q, dropCount_d;
    logic [18:0]    pixCount_q, pixCount_d;
    logic [18:0]    target_q, target_d;
    logic           frameDone_q, frameDone_d;

    logic           grantFound;
    logic [PW-1:0]  grantIdx;
    logic           inRange;
    logic [18:0]    pixAddr;
    logic [18:0]    pixInc;

    // Counts above MAX_ITER are clamped first so both palettes see the same range.
    function automatic logic [7:0] colorOf(input logic [10:0] c);
        logic [10:0] cs;
        logic [7:0]  col;
        cs  = (c > MAX_C) ? MAX_C : c;
        col = 8'h00;
`ifdef ITER_COLOR_MAP_EN
        if (cs >= MAX_C)           col = 8'h00;
        else if (cs >= (MAX_C >> 1)) col = 8'hE0;
        else if (cs >= (MAX_C >> 2)) col = 8'hFC;
        else if (cs >= (MAX_C >> 3)) col = 8'h1C;
        else if (cs >= (MAX_C >> 4)) col = 8'h1F;
        else                         col = 8'h03;
`else
        col = (cs > 11'd255) ? 8'hFF : cs[7:0];
`endif
        return col;
    endfunction

    // Search starts at rrPtr_q so the last grantee has lowest priority next time.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NUM_ITER; k++) begin
            int idx;
            idx = int'(rrPtr_q) + k;
            if (idx >= NUM_ITER) idx = idx - NUM_ITER;
            if (!grantFound && res_valid[idx]) begin
                grantFound = 1'b1;
                grantIdx   = PW'(idx);
            end
        end
    end

    always_comb begin
        res_ready = '0;
        if (reset && state_q == IDLE && grantFound) res_ready[grantIdx] = 1'b1;
    end

    assign inRange = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
    assign pixAddr = 19'(y_q) * 19'(H_RES) + 19'(x_q);

    // The frame length is re-sampled whenever the pixel counter sits at zero.
    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        x_d         = x_q;
        y_d         = y_q;
        count_d     = count_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        dropCount_d = dropCount_q;
        pixCount_d  = pixCount_q;
        target_d    = (pixCount_q == 19'd0) ? total_pixels : target_q;
        frameDone_d = 1'b0;
        pixInc      = pixCount_q + 19'd1;
        case (state_q)
            IDLE: begin
                if (grantFound) begin
                    x_d     = res_x[int'(grantIdx)*10 +: 10];
                    y_d     = res_y[int'(grantIdx)*9 +: 9];
                    count_d = res_count[int'(grantIdx)*11 +: 11];
                    rrPtr_d = (int'(grantIdx) == NUM_ITER - 1) ? '0 : grantIdx + PW'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (inRange) begin
                    memAddr_d = pixAddr;
                    memData_d = colorOf(count_q);
                    state_d   = WRITE;
                end else begin
                    if (dropCount_q != 16'hFFFF) dropCount_d = dropCount_q + 16'd1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    if (target_q != 19'd0 && pixInc == target_q) begin
                        pixCount_d  = 19'd0;
                        frameDone_d = 1'b1;
                    end else begin
                        pixCount_d = pixInc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rrPtr_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            count_q     <= '0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            dropCount_q <= '0;
            pixCount_q  <= '0;
            target_q    <= '0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            count_q     <= count_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            dropCount_q <= dropCount_d;
            pixCount_q  <= pixCount_d;
            target_q    <= target_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = memAddr_q;
    assign mem_data   = memData_q;
    assign frame_done = frameDone_q;
    assign drop_count = dropCount_q;

endmodule

// File: tb/tb_iter_result_collector.sv
// Directed self-checking bench for iter_result_collector (two iterators, 640x480, 4-pixel frames).
// Honours ITER_COLOR_MAP_EN when choosing expected pixel colours.
module tb_iter_result_collector;

    logic        clk;
    logic        reset;
    logic [1:0]  res_valid;
    logic [1:0]  res_ready;
    logic [19:0] res_x;
    logic [17:0] res_y;
    logic [21:0] res_count;
    logic [18:0] total_pixels;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic        frame_done;
    logic [15:0] drop_count;

    int testCount = 0;
    int failCount = 0;

`ifdef ITER_COLOR_MAP_EN
    localparam logic [7:0] C3 = 8'h03, C5 = 8'h03, C7 = 8'h1F, C9 = 8'h1F;
    localparam logic [7:0] C20 = 8'h1C, C50 = 8'hE0, C100 = 8'h00;
`else
    localparam logic [7:0] C3 = 8'h03, C5 = 8'h05, C7 = 8'h07, C9 = 8'h09;
    localparam logic [7:0] C20 = 8'h14, C50 = 8'h32, C100 = 8'h64;
`endif

    iter_result_collector dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_x        (res_x),
        .res_y        (res_y),
        .res_count    (res_count),
        .total_pixels (total_pixels),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .frame_done   (frame_done),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [9:0] x0, input logic [8:0] y0, input logic [10:0] c0,
                                 input logic [9:0] x1, input logic [8:0] y1, input logic [10:0] c1);
        res_valid = v;
        res_x     = {x1, x0};
        res_y     = {y1, y0};
        res_count = {c1, c0};
    endtask

    // One full transfer from the current IDLE cycle through WRITE and back to IDLE.
    task automatic runTransfer(input string tag, input logic [1:0] expReady,
                               input logic [18:0] expAddr, input logic [7:0] expData,
                               input int waitCycles, input logic expFrame);
        #1;
        checkOutput({tag, "_ready"}, 32'(res_ready), 32'(expReady));
        @(negedge clk);
        checkOutput({tag, "_cap_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_cap_ready"}, 32'(res_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < waitCycles; i++) begin
            mem_ack = 1'b0;
            #1;
            checkOutput({tag, "_hold_we"}, 32'(mem_we), 32'd1);
            checkOutput({tag, "_hold_addr"}, 32'(mem_addr), 32'(expAddr));
            checkOutput({tag, "_hold_data"}, 32'(mem_data), 32'(expData));
            checkOutput({tag, "_hold_ready"}, 32'(res_ready), 32'd0);
            @(negedge clk);
        end
        mem_ack = 1'b1;
        #1;
        checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(expAddr));
        checkOutput({tag, "_data"}, 32'(mem_data), 32'(expData));
        @(negedge clk);
        checkOutput({tag, "_we_off"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_frame"}, 32'(frame_done), 32'(expFrame));
    endtask

    initial begin
        reset        = 1'b0;
        mem_ack      = 1'b1;
        total_pixels = 19'd4;
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_data", 32'(mem_data), 32'd0);
        checkOutput("rst_frame", 32'(frame_done), 32'd0);
        checkOutput("rst_drop", 32'(drop_count), 32'd0);
        checkOutput("rst_ready", 32'(res_ready), 32'd0);

        // Both iterators valid continuously: grants alternate, fourth write closes the frame.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(2'b11, 10'd1, 9'd0, 11'd5, 10'd2, 9'd0, 11'd7);
        runTransfer("rr0", 2'b01, 19'd1, C5, 0, 1'b0);
        runTransfer("rr1", 2'b10, 19'd2, C7, 0, 1'b0);
        runTransfer("rr2", 2'b01, 19'd1, C5, 0, 1'b0);
        runTransfer("rr3", 2'b10, 19'd2, C7, 0, 1'b1);
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rr_frame_single", 32'(frame_done), 32'd0);

        // Single in-set pixel at (3,2).
        applyStimulus(2'b01, 10'd3, 9'd2, 11'd100, 0, 0, 0);
        runTransfer("single", 2'b01, 19'd1283, C100, 0, 1'b0);

        // Bottom-right pixel with an over-range count and a stalled memory.
        applyStimulus(2'b10, 0, 0, 0, 10'd639, 9'd479, 11'd300);
        runTransfer("hold", 2'b10, 19'd307199, C100, 5, 1'b0);

        // Out-of-range results are dropped without any write.
        applyStimulus(2'b01, 10'd640, 9'd0, 11'd10, 0, 0, 0);
        #1;
        checkOutput("dropx_ready", 32'(res_ready), 32'b01);
        @(negedge clk);
        checkOutput("dropx_cap_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput("dropx_we", 32'(mem_we), 32'd0);
        checkOutput("dropx_count", 32'(drop_count), 32'd1);
        applyStimulus(2'b10, 0, 0, 0, 10'd0, 9'd480, 11'd10);
        #1;
        checkOutput("dropy_ready", 32'(res_ready), 32'b10);
        @(negedge clk);
        @(negedge clk);
        checkOutput("dropy_we", 32'(mem_we), 32'd0);
        checkOutput("dropy_count", 32'(drop_count), 32'd2);

        // Pixels three and four of the second frame, then first of the third.
        applyStimulus(2'b01, 10'd5, 9'd1, 11'd50, 0, 0, 0);
        runTransfer("f3", 2'b01, 19'd645, C50, 0, 1'b0);
        applyStimulus(2'b10, 0, 0, 0, 10'd6, 9'd1, 11'd20);
        runTransfer("f4", 2'b10, 19'd646, C20, 0, 1'b1);
        applyStimulus(2'b01, 10'd7, 9'd1, 11'd3, 0, 0, 0);
        runTransfer("f5", 2'b01, 19'd647, C3, 0, 1'b0);
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("f5_frame_low", 32'(frame_done), 32'd0);

        // Reset in the middle of a stalled write.
        applyStimulus(2'b10, 0, 0, 0, 10'd10, 9'd0, 11'd9);
        #1;
        checkOutput("mid_ready", 32'(res_ready), 32'b10);
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("mid_we_before", 32'(mem_we), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid_we", 32'(mem_we), 32'd0);
        checkOutput("mid_addr", 32'(mem_addr), 32'd0);
        checkOutput("mid_data", 32'(mem_data), 32'd0);
        checkOutput("mid_drop", 32'(drop_count), 32'd0);
        checkOutput("mid_ready_rst", 32'(res_ready), 32'd0);
        checkOutput("mid_frame", 32'(frame_done), 32'd0);
        @(negedge clk);
        checkOutput("mid_we_held", 32'(mem_we), 32'd0);
        reset   = 1'b1;
        mem_ack = 1'b1;
        runTransfer("post", 2'b10, 19'd10, C9, 0, 1'b0);
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("post_idle_we", 32'(mem_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
